// File: rtl/mmcm_drp_reconfig_master_if.sv
// AXI4-Lite bundle between the reconfiguration master and the DRP bridge.
// The m modport is the master view; s is the bridge view.
interface jelly3_axi4l_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = DATA_BITS / 8
) (
  input logic aclk,
  input logic aresetn
);
  logic [ADDR_BITS-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BITS-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport m (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport s (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/mmcm_drp_reconfig_master.sv
// Walks a ROM table of masked DRP writes over AXI4-Lite while holding the MMCM in
// reset, then releases it and waits (bounded) for LOCKED.
module mmcm_drp_reconfig_master #(
  parameter int IDX_BITS     = 5,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [IDX_BITS-1:0] tbl_base,
  output logic [IDX_BITS-1:0] tbl_index,
  input  logic [39:0]         tbl_entry,
  jelly3_axi4l_if.m           m_axi4l,
  output logic                mmcm_rst,
  input  logic                mmcm_locked,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [3:0]          dbg_state
);

  // Handshakes: a channel transfers on a rising aclk edge where valid and ready
  // are both 1; valid never drops before that edge and no payload changes while
  // valid is held.

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_TERM = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, FETCH, RD_ADDR, RD_DATA, WR, WR_RESP, RELEASE, WAIT_LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [39:0]         entry_q, entry_d;
  logic [15:0]         rdata_q, rdata_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                rst_q, rst_d;
  logic                lock_s1_q, lock_s2_q;
  logic                aw_hs, w_hs;
  logic [15:0]         wr_value;

  // mask bit 1 keeps the bit read back from the DRP register
  assign wr_value = (rdata_q & entry_q[31:16]) | (entry_q[15:0] & ~entry_q[31:16]);
  assign aw_hs    = m_axi4l.awvalid && m_axi4l.awready;
  assign w_hs     = m_axi4l.wvalid && m_axi4l.wready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    entry_d    = entry_q;
    rdata_d    = rdata_q;
    timer_d    = timer_q;
    fetch_ph_d = fetch_ph_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    rst_d      = rst_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = tbl_base;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          rst_d   = 1'b1;
          state_d = ASSERT_RST;
        end
      end
      ASSERT_RST: state_d = FETCH;
      FETCH: begin
        // phase 0 presents the address, phase 1 captures the ROM output
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          entry_d    = tbl_entry;
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: if (m_axi4l.arready) state_d = RD_DATA;
      RD_DATA: begin
        if (m_axi4l.rvalid) begin
          rdata_d = m_axi4l.rdata[15:0];
          if (m_axi4l.rresp != 2'b00) error_d = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      WR_RESP: begin
        if (m_axi4l.bvalid) begin
          if (m_axi4l.bresp != 2'b00) error_d = 1'b1;
          if (entry_q[39]) begin
            rst_d   = 1'b0;
            state_d = RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      RELEASE: begin
        timer_d = '0;
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (timer_q != TIMER_TERM) timer_d = timer_q + 1'b1;
        if (lock_s2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_q >= TIMER_LAST) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      entry_q    <= '0;
      rdata_q    <= '0;
      timer_q    <= '0;
      fetch_ph_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rst_q      <= 1'b0;
      lock_s1_q  <= 1'b0;
      lock_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      rdata_q    <= rdata_d;
      timer_q    <= timer_d;
      fetch_ph_q <= fetch_ph_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rst_q      <= rst_d;
      lock_s1_q  <= mmcm_locked;
      lock_s2_q  <= lock_s1_q;
    end
  end

  assign tbl_index = idx_q;
  assign mmcm_rst  = rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

  assign m_axi4l.araddr  = {entry_q[38:32], 1'b0};
  assign m_axi4l.arprot  = 3'b000;
  assign m_axi4l.arvalid = (state_q == RD_ADDR);
  assign m_axi4l.rready  = (state_q == RD_DATA);
  assign m_axi4l.awaddr  = {entry_q[38:32], 1'b0};
  assign m_axi4l.awprot  = 3'b000;
  assign m_axi4l.awvalid = (state_q == WR) && !aw_done_q;
  assign m_axi4l.wdata   = {16'h0000, wr_value};
  assign m_axi4l.wstrb   = 4'hf;
  assign m_axi4l.wvalid  = (state_q == WR) && !w_done_q;
  assign m_axi4l.bready  = (state_q == WR_RESP);

endmodule

// File: doc/mmcm_drp_reconfig_master.md
MMCM_DRP_RECONFIG_MASTER -- requirements
Module: mmcm_drp_reconfig_master

Interface
REQ-001 SHALL have parameter IDX_BITS, default 5: table index width; at most 2^IDX_BITS entries per sequence.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: max aclk cycles to wait for lock after releasing reset.
REQ-003 SHALL have port aclk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a reconfiguration sequence.
REQ-006 SHALL have port tbl_base, input, IDX_BITS: first table index, sampled on an accepted start.
REQ-007 SHALL have port tbl_index, output, IDX_BITS: table read address; external ROM has 1-cycle read latency.
REQ-008 SHALL have port tbl_entry, input, 40: {last[39], daddr[38:32], mask[31:16], data[15:0]}.
REQ-009 SHALL have port m_axi4l, jelly3_axi4l_if.m, ADDR 8 / DATA 32: AXI4-Lite master to the DRP bridge; interface aclk/aresetn tied to the same domain.
REQ-010 SHALL have port mmcm_rst, output, 1: MMCM reset request.
REQ-011 SHALL have port mmcm_locked, input, 1: asynchronous MMCM LOCKED.
REQ-012 SHALL have ports busy, done, error, output, 1 each: status flags.

Function
REQ-013 SHALL implement states IDLE, ASSERT_RST, FETCH, RD_ADDR, RD_DATA, WR, WR_RESP, RELEASE, WAIT_LOCK.
REQ-014 SHALL, in IDLE, on start: latch tbl_base into the index, clear done and error, set busy, and go to ASSERT_RST; start SHALL be ignored while busy=1.
REQ-015 SHALL, in ASSERT_RST, set mmcm_rst=1 for one cycle, then go to FETCH; mmcm_rst SHALL stay 1 until RELEASE.
REQ-016 SHALL, in FETCH, drive tbl_index for one cycle, register tbl_entry on the next cycle, then go to RD_ADDR.
REQ-017 SHALL, in RD_ADDR, drive araddr={daddr,1'b0} with arvalid=1 until arready, then go to RD_DATA.
REQ-018 SHALL, in RD_DATA, hold rready=1, capture rdata[15:0] on the rvalid handshake, and go to WR.
REQ-019 SHALL write value (rdata & mask) | (data & ~mask); mask bit 1 means the bit is kept.
REQ-020 SHALL, in WR, assert awvalid and wvalid together on the same cycle with awaddr={daddr,1'b0}, wdata={16'h0,value}, wstrb=4'hf.
REQ-021 SHALL deassert each of awvalid and wvalid only after its own handshake, and go to WR_RESP only when both have completed.
REQ-022 SHALL, in WR_RESP, hold bready=1 until bvalid; then, if last=1, go to RELEASE, else increment the index (mod 2^IDX_BITS) and go to FETCH.
REQ-023 SHALL treat a nonzero rresp or bresp as an error: set error=1 (sticky until the next start) and continue the sequence.
REQ-024 SHALL, in RELEASE, drive mmcm_rst=0, clear the lock timer, and go to WAIT_LOCK.
REQ-025 SHALL synchronise mmcm_locked through two flops before use.
REQ-026 SHALL, in WAIT_LOCK, on synchronised lock=1, set done=1, clear busy, and go to IDLE.
REQ-027 SHALL, in WAIT_LOCK, if the timer reaches LOCK_TIMEOUT first, set error=1 and done=1, clear busy, and go to IDLE.
REQ-028 SHALL stop the timer at its terminal value; the timer SHALL NOT wrap.
REQ-029 SHALL hold done=1 until the next accepted start.
REQ-030 SHALL tie arprot and awprot to 0.
REQ-031 SHALL never have a read and a write outstanding at the same time.

Reset
REQ-032 SHALL, while aresetn=0, asynchronously force: state=IDLE, busy=0, done=0, error=0, mmcm_rst=0, all valid/ready outputs=0, index=0, timer=0.
REQ-033 SHALL NOT complete any AXI transfer in flight when aresetn asserts mid-sequence, and SHALL NOT resume it after reset.

Verification
REQ-034 Single entry {last=1, daddr=0x08, mask=0x1000, data=0x0041}, DRP model holds 0x1FFF, lock follows 20 cycles after mmcm_rst falls -> araddr=0x10, awaddr=0x10, wdata=0x1041, done=1, error=0.
REQ-035 Three entries from tbl_base=30, IDX_BITS=5 -> indices 30, 31, 0 are fetched; exactly 3 reads and 3 writes; mmcm_rst stays high throughout.
REQ-036 Bridge delays awready 5 cycles and wready 1 cycle -> wvalid drops after 1 cycle, awvalid is held for 5 cycles, and a single write completes.
REQ-037 LOCK_TIMEOUT=100, mmcm_locked held at 0 -> error=1 and done=1 at exactly 100 cycles after WAIT_LOCK is entered; busy=0.
REQ-038 start pulsed while busy, then aresetn pulsed low during RD_DATA -> the second start has no effect; after reset all outputs are at reset values and no bready is seen.
REQ-039 Bridge returns bresp=2'b10 on the first write -> the sequence completes, error=1, done=1.
